adder_4bit_reg: RTL and testbench
=================================

Name: adder_4bit_reg

Overview:
- Registered 4-bit ripple-carry adder/subtractor built from WIDTH chained full-adder cells.
- Adds or subtracts two unsigned/two's-complement operands with carry-in, and produces sum, carry-out, signed overflow and zero flags.
- Outputs are registered, with one-cycle latency and a valid qualifier.
- Serves as the arithmetic primitive for small datapaths and as a unit-level check of the full-adder cell chain.

Parameters:
- WIDTH, 4, operand/sum width in bits; must be ≥1; verified at 4.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low; release synchronous to clk by the integrator.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-adjust (subtract); see Behaviour.
- sub  input  1  0 = add, 1 = subtract (A − B).
- in_valid  input  1  operands valid this cycle.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out of the MSB cell (subtract: 1 = no borrow).
- ovf  output  1  registered signed overflow.
- zero  output  1  registered flag, 1 when sum == 0.
- out_valid  output  1  registered; result fields valid.

Behaviour:
- Reset: while rst_n = 0, sum = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0, regardless of clk.
  - Asserting reset mid-operation discards any in-flight result.
  - The first capture after release happens on the first rising edge with rst_n = 1.
- Datapath (combinational, before the output register):
  - b_eff = b XOR {WIDTH{sub}}; c0 = cin XOR sub.
  - Cell i: s_i = a_i ^ b_eff_i ^ c_i; c_{i+1} = a_i&b_eff_i | a_i&c_i | b_eff_i&c_i.
  - Result = {c_WIDTH, s} = a + b_eff + c0, computed modulo 2^(WIDTH+1).
- Add (sub = 0): {cout, sum} = a + b + cin exactly, range 0..2·(2^WIDTH−1)+1.
- Subtract (sub = 1, cin = 0): sum = (a − b) mod 2^WIDTH; cout = 1 iff a ≥ b unsigned.
- Subtract (sub = 1, cin = 1): sum = a − b − 1 (borrow-in); cout = 1 iff a ≥ b+1.
- ovf = c_WIDTH XOR c_{WIDTH−1}, i.e. the signed two's-complement result is not representable.
- zero = (s == 0), evaluated on the same captured result.
- Latency: exactly 1 cycle.
  - On a rising edge with in_valid = 1, sum/cout/ovf/zero load the result of that cycle's inputs, and out_valid = 1.
  - On a rising edge with in_valid = 0, out_valid = 0 and result registers hold their previous values.
- Back-to-back: a new operand set accepted every cycle; no backpressure, no stall.
- Wrap-around: results are truncated to WIDTH bits, and the overflowed carry appears only on cout.
- X/undriven inputs while in_valid = 0 must not affect outputs.
- No internal state beyond the output registers; no FSM.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1, a = F, b = F → all outputs 0. Release, then a = 0, b = 0, cin = 0, sub = 0 → next edge: sum = 0, cout = 0, zero = 1, out_valid = 1.
- Add sweep:
  - a = 4, b = 1, cin = 0 → sum = 5, cout = 0.
  - a = 9, b = 3 → sum = C, cout = 0, ovf = 0.
  - a = D, b = D → sum = A, cout = 1.
  - a = F, b = F, cin = 0 → sum = E, cout = 1, ovf = 0.
  - a = F, b = F, cin = 1 → sum = F, cout = 1.
- Signed overflow:
  - a = 7, b = 1, add → sum = 8, ovf = 1, cout = 0.
  - a = 8, b = 8, add → sum = 0, cout = 1, ovf = 1, zero = 1.
- Subtract:
  - sub = 1, cin = 0, a = 5, b = 3 → sum = 2, cout = 1.
  - a = 3, b = 5 → sum = E, cout = 0.
  - a = 8, b = 1 → sum = 7, ovf = 1.
  - sub = 1, cin = 1, a = 5, b = 3 → sum = 1.
- Handshake:
  - Drive 3 consecutive valid operand sets → 3 consecutive out_valid cycles with matching results.
  - Then drop in_valid → out_valid = 0 and sum holds the last value.
- Async reset mid-stream: assert rst_n = 0 between edges → outputs clear immediately without a clock edge. Exhaustive 512-vector add/sub sweep compared against a + b_eff + c0 reference model.

Source files
------------

// File: rtl/adder_4bit_reg_if.sv
// rtl/adder_4bit_reg_if.sv - operand/result bundle for the registered adder/subtractor
interface adder_4bit_reg_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             out_valid;

  modport master (
    output a, b, cin, sub, in_valid,
    input  sum, cout, ovf, zero, out_valid
  );

  modport slave (
    input  a, b, cin, sub, in_valid,
    output sum, cout, ovf, zero, out_valid
  );
endinterface

// File: rtl/adder_4bit_reg.sv
// rtl/adder_4bit_reg.sv - ripple-carry add/sub from chained full-adder cells, registered outputs
module adder_4bit_reg #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_4bit_reg_if.slave bus
);
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH:0]   w_c;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_valid;

  // Subtract is A + ~B + 1; cin then acts as a borrow-in, hence c0 = cin ^ sub.
  assign w_b_eff = bus.b ^ {WIDTH{bus.sub}};
  assign w_c[0]  = bus.cin ^ bus.sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_s[i]   = bus.a[i] ^ w_b_eff[i] ^ w_c[i];
    assign w_c[i+1] = (bus.a[i] & w_b_eff[i]) | (bus.a[i] & w_c[i]) | (w_b_eff[i] & w_c[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      // Result registers only load on valid so idle/undriven operands never leak through.
      if (bus.in_valid) begin
        r_sum  <= w_s;
        r_cout <= w_c[WIDTH];
        r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
        r_zero <= (w_s == '0);
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_adder_4bit_reg.sv
// tb/tb_adder_4bit_reg.sv - directed and exhaustive scoreboard bench for adder_4bit_reg
module tb_adder_4bit_reg;
  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t q_exp[$];
  exp_t last_exp;

  adder_4bit_reg_if #(.WIDTH(4)) bus ();

  adder_4bit_reg #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                 input logic cin, input logic sub);
    exp_t       e;
    logic [3:0] be;
    logic       c0;
    logic [4:0] r;
    int         sa;
    int         sb;
    int         s;
    be = sub ? ~b : b;
    c0 = cin ^ sub;
    r  = {1'b0, a} + {1'b0, be} + {4'b0, c0};
    sa = a[3]  ? int'(a) - 16  : int'(a);
    sb = be[3] ? int'(be) - 16 : int'(be);
    s  = sa + sb + int'(c0);
    e.sum  = r[3:0];
    e.cout = r[4];
    e.ovf  = (s > 7) || (s < -8);
    e.zero = (r[3:0] == 4'h0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic want(input string tag, input logic [3:0] s, input logic c,
                      input logic o, input logic z);
    chk({tag, ".sum"},  {4'h0, bus.sum},  {4'h0, s});
    chk({tag, ".cout"}, {7'h0, bus.cout}, {7'h0, c});
    chk({tag, ".ovf"},  {7'h0, bus.ovf},  {7'h0, o});
    chk({tag, ".zero"}, {7'h0, bus.zero}, {7'h0, z});
  endtask

  // Drives one cycle of stimulus after an edge, then checks the edge that follows.
  task automatic cycle(input string tag, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic cin, input logic sub);
    exp_t e;
    bus.in_valid = v;
    bus.a   = v ? a : 4'bxxxx;
    bus.b   = v ? b : 4'bxxxx;
    bus.cin = v ? cin : 1'bx;
    bus.sub = v ? sub : 1'bx;
    if (v) q_exp.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {7'h0, bus.out_valid}, {7'h0, v});
    if (v) begin
      if (q_exp.size() == 0) begin
        chk({tag, ".sb_empty"}, 8'd1, 8'd0);
      end else begin
        e = q_exp.pop_front();
        last_exp = e;
        want(tag, e.sum, e.cout, e.ovf, e.zero);
      end
    end else begin
      chk({tag, ".hold"}, {4'h0, bus.sum}, {4'h0, last_exp.sum});
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    bus.in_valid = 1'b1;
    bus.a   = 4'hF;
    bus.b   = 4'hF;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    want("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.valid", {7'h0, bus.out_valid}, 8'h0);
    rst_n = 1'b1;

    cycle("first", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    want("first_d", 4'h0, 1'b0, 1'b0, 1'b1);

    cycle("add_4_1", 1'b1, 4'h4, 4'h1, 1'b0, 1'b0);
    want("add_4_1_d", 4'h5, 1'b0, 1'b0, 1'b0);
    cycle("add_9_3", 1'b1, 4'h9, 4'h3, 1'b0, 1'b0);
    want("add_9_3_d", 4'hC, 1'b0, 1'b0, 1'b0);
    cycle("add_D_D", 1'b1, 4'hD, 4'hD, 1'b0, 1'b0);
    want("add_D_D_d", 4'hA, 1'b1, 1'b0, 1'b0);
    cycle("add_F_F", 1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
    want("add_F_F_d", 4'hE, 1'b1, 1'b0, 1'b0);
    cycle("add_F_F_c", 1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
    want("add_F_F_c_d", 4'hF, 1'b1, 1'b0, 1'b0);
    cycle("ovf_7_1", 1'b1, 4'h7, 4'h1, 1'b0, 1'b0);
    want("ovf_7_1_d", 4'h8, 1'b0, 1'b1, 1'b0);
    cycle("ovf_8_8", 1'b1, 4'h8, 4'h8, 1'b0, 1'b0);
    want("ovf_8_8_d", 4'h0, 1'b1, 1'b1, 1'b1);

    cycle("sub_5_3", 1'b1, 4'h5, 4'h3, 1'b0, 1'b1);
    want("sub_5_3_d", 4'h2, 1'b1, 1'b0, 1'b0);
    cycle("sub_3_5", 1'b1, 4'h3, 4'h5, 1'b0, 1'b1);
    want("sub_3_5_d", 4'hE, 1'b0, 1'b0, 1'b0);
    cycle("sub_8_1", 1'b1, 4'h8, 4'h1, 1'b0, 1'b1);
    want("sub_8_1_d", 4'h7, 1'b1, 1'b1, 1'b0);
    cycle("sub_5_3_b", 1'b1, 4'h5, 4'h3, 1'b1, 1'b1);
    want("sub_5_3_b_d", 4'h1, 1'b1, 1'b0, 1'b0);

    cycle("hs0", 1'b1, 4'h2, 4'h6, 1'b0, 1'b0);
    cycle("hs1", 1'b1, 4'hA, 4'h4, 1'b1, 1'b1);
    cycle("hs2", 1'b1, 4'hC, 4'h1, 1'b1, 1'b0);
    cycle("idle0", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    want("idle0_d", 4'hE, 1'b0, 1'b0, 1'b0);
    cycle("idle1", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    cycle("pre_rst", 1'b1, 4'h6, 4'h7, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    want("async_rst", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("async_rst.valid", {7'h0, bus.out_valid}, 8'h0);
    #1;
    rst_n = 1'b1;
    last_exp = '0;
    q_exp.delete();

    for (int v = 0; v < 512; v++) begin
      logic [8:0] vec;
      vec = v[8:0];
      cycle("sweep", 1'b1, vec[3:0], vec[7:4], 1'($urandom_range(0, 1)), vec[8]);
    end

    chk("sb_drained", 8'(q_exp.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
